// File: rtl/slot_expander.sv
// slot_expander: MSX primary/secondary slot decoder with I/O RAM mapper.
// Mapper register readback is enabled by defining SLOT_MAPPER_READBACK_EN.
module slot_expander #(
   parameter logic [3:0] EXPANDED  = 4'b1000,
   parameter int         RAM_PSLOT = 3,
   parameter int         RAM_SSLOT = 0,
   parameter int         SEG_BITS  = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [15:0]            addr,
   input  logic [7:0]             d_in,
   input  logic                   mreq_n,
   input  logic                   iorq_n,
   input  logic                   m1_n,
   input  logic                   rd_n,
   input  logic                   wr_n,
   input  logic                   rfrsh_n,
   input  logic [7:0]             prim_slot,
   output logic [15:0]            sltsl_n,
   output logic [SEG_BITS+13:0]   ram_addr,
   output logic                   ram_we,
   output logic [7:0]             d_out,
   output logic                   d_oe
);

   localparam logic [1:0] RAM_P = 2'(RAM_PSLOT);
   localparam logic [1:0] RAM_S = EXPANDED[RAM_PSLOT] ? 2'(RAM_SSLOT) : 2'd0;

   logic [7:0]          sub_reg_q [4];
   logic [7:0]          sub_reg_d [4];
   logic [SEG_BITS-1:0] seg_q [4];
   logic [SEG_BITS-1:0] seg_d [4];
   logic                wr_q;
   logic                wr_d;
   logic [SEG_BITS+13:0] ram_addr_q;
   logic [SEG_BITS+13:0] ram_addr_d;

   logic [1:0] pg;
   logic [1:0] p;
   logic [1:0] s;
   logic       mem_cyc;
   logic       ffff_hit;
   logic       io_hit;
   logic       wr_edge;
   logic       ram_sel;
`ifdef SLOT_MAPPER_READBACK_EN
   logic [7:0] rb;
`endif

   always_comb begin
      pg       = addr[15:14];
      p        = 2'(prim_slot >> {pg, 1'b0});
      s        = EXPANDED[p] ? 2'(sub_reg_q[p] >> {pg, 1'b0}) : 2'd0;
      mem_cyc  = ~mreq_n & rfrsh_n;
      ffff_hit = (addr == 16'hFFFF) & EXPANDED[p];
      io_hit   = ~iorq_n & m1_n & (addr[7:2] == 6'h3F);
      // wr_q low after reset forces a fresh high-to-low edge
      wr_edge  = ~wr_n & wr_q;
      ram_sel  = mem_cyc & ~ffff_hit & (p == RAM_P) & (s == RAM_S);
   end

   always_comb begin
      sltsl_n  = 16'hFFFF;
      ram_we   = 1'b0;
      ram_addr = ram_addr_q;
      d_out    = 8'hFF;
      d_oe     = 1'b0;
`ifdef SLOT_MAPPER_READBACK_EN
      rb       = 8'hFF;
      rb[SEG_BITS-1:0] = seg_q[addr[1:0]];
`endif
      if (reset_n) begin
         if (mem_cyc && !ffff_hit)
            sltsl_n[{p, s}] = 1'b0;
         if (mem_cyc && ffff_hit && !rd_n) begin
            d_oe  = 1'b1;
            d_out = ~sub_reg_q[p];
         end
         if (ram_sel) begin
            ram_addr = {seg_q[pg], addr[13:0]};
            ram_we   = ~wr_n;
         end
`ifdef SLOT_MAPPER_READBACK_EN
         if (io_hit && !rd_n) begin
            d_oe  = 1'b1;
            d_out = rb;
         end
`endif
      end
   end

   always_comb begin
      sub_reg_d  = sub_reg_q;
      seg_d      = seg_q;
      wr_d       = wr_n;
      ram_addr_d = ram_addr;
      if (mem_cyc && ffff_hit && wr_edge)
         sub_reg_d[p] = d_in;
      if (io_hit && wr_edge)
         seg_d[addr[1:0]] = d_in[SEG_BITS-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sub_reg_q  <= '{default: 8'h00};
         seg_q[0]   <= SEG_BITS'(3);
         seg_q[1]   <= SEG_BITS'(2);
         seg_q[2]   <= SEG_BITS'(1);
         seg_q[3]   <= SEG_BITS'(0);
         wr_q       <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         sub_reg_q  <= sub_reg_d;
         seg_q      <= seg_d;
         wr_q       <= wr_d;
         ram_addr_q <= ram_addr_d;
      end
   end

endmodule
